// File: rtl/fc_rx_credit_ctrl.sv
// rtl/fc_rx_credit_ctrl.sv - receive-side PCIe flow-control credit manager (InitFC/UpdateFC)
// Optional timer-driven UpdateFC under macro FC_RX_UPDATE_TIMER_EN.
module fc_rx_credit_ctrl #(
    parameter int HDR_CREDITS        = 32,
    parameter int DATA_CREDITS       = 256,
    parameter int UPDATE_HDR_THRESH  = 4,
    parameter int UPDATE_DATA_THRESH = 16,
    parameter int UPDATE_TIMER_CYC   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up_i,
    input  logic        rx_tlp_valid_i,
    input  logic [1:0]  rx_tlp_type_i,
    input  logic [7:0]  rx_tlp_size_i,
    input  logic        rx_release_valid_i,
    input  logic [7:0]  rx_release_hdr_i,
    input  logic [11:0] rx_release_data_i,
    output logic        fc_dllp_valid_o,
    input  logic        fc_dllp_ready_i,
    output logic        fc_dllp_type_o,
    output logic [7:0]  fc_hdr_credit_o,
    output logic [11:0] fc_data_credit_o,
    output logic [7:0]  avail_hdr_o,
    output logic [11:0] avail_data_o,
    output logic        overflow_err_o
);

    localparam logic [7:0]  INIT_HDR   = 8'(HDR_CREDITS);
    localparam logic [11:0] INIT_DATA  = 12'(DATA_CREDITS);
    localparam logic [7:0]  THR_HDR    = 8'(UPDATE_HDR_THRESH);
    localparam logic [11:0] THR_DATA   = 12'(UPDATE_DATA_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ca_hdr_q,  ca_hdr_d;
    logic [11:0] ca_data_q, ca_data_d;
    logic [7:0]  cr_hdr_q,  cr_hdr_d;
    logic [11:0] cr_data_q, cr_data_d;
    logic [7:0]  adv_hdr_q, adv_hdr_d;
    logic [11:0] adv_data_q, adv_data_d;
    logic [7:0]  lat_hdr_q, lat_hdr_d;
    logic [11:0] lat_data_q, lat_data_d;
    logic        ovf_q, ovf_d;

    logic        counting;
    logic        tlp_counts;
    logic        tlp_has_data;
    logic [7:0]  cost_hdr;
    logic [11:0] cost_data;
    logic [7:0]  avail_hdr;
    logic [11:0] avail_data;
    logic [7:0]  pend_hdr;
    logic [11:0] pend_data;
    logic        thresh_hit;
    logic        timer_hit;

    assign counting     = (state_q == ST_ACTIVE) || (state_q == ST_UPDATE);
    assign tlp_counts   = rx_tlp_valid_i && (rx_tlp_type_i != 2'b11);
    assign tlp_has_data = rx_tlp_valid_i && ((rx_tlp_type_i == 2'b00) || (rx_tlp_type_i == 2'b10));
    assign cost_hdr     = {7'd0, tlp_counts};
    assign cost_data    = tlp_has_data ? 12'(({1'b0, rx_tlp_size_i} + 9'd3) >> 2) : 12'd0;

    assign avail_hdr    = ca_hdr_q - cr_hdr_q;
    assign avail_data   = ca_data_q - cr_data_q;
    assign pend_hdr     = ca_hdr_q - adv_hdr_q;
    assign pend_data    = ca_data_q - adv_data_q;
    assign thresh_hit   = (pend_hdr >= THR_HDR) || (pend_data >= THR_DATA);

`ifdef FC_RX_UPDATE_TIMER_EN
    localparam int TMR_W = (UPDATE_TIMER_CYC > 1) ? $clog2(UPDATE_TIMER_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_TIMER_CYC - 1);

    logic [TMR_W-1:0] timer_q, timer_d;

    // Restarts on every FC handshake so the period is measured from the last advertisement.
    always_comb begin
        timer_d = timer_q;
        if (!link_up_i || (fc_dllp_valid_o && fc_dllp_ready_i)) begin
            timer_d = '0;
        end else if (state_q == ST_ACTIVE) begin
            timer_d = (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_hit = (state_q == ST_ACTIVE) && (timer_q == TMR_LAST) &&
                       ((pend_hdr != 8'd0) || (pend_data != 12'd0));
`else
    // Timer period has no effect without the timer.
    assign timer_hit = 1'b0 & (UPDATE_TIMER_CYC != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!link_up_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_INIT;
                ST_INIT:   if (fc_dllp_ready_i) state_d = ST_ACTIVE;
                ST_ACTIVE: if (thresh_hit || timer_hit) state_d = ST_UPDATE;
                ST_UPDATE: if (fc_dllp_ready_i) state_d = ST_ACTIVE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fc_dllp_valid_o  = 1'b0;
        fc_dllp_type_o   = 1'b0;
        fc_hdr_credit_o  = 8'd0;
        fc_data_credit_o = 12'd0;
        case (state_q)
            ST_INIT: begin
                fc_dllp_valid_o  = 1'b1;
                fc_hdr_credit_o  = INIT_HDR;
                fc_data_credit_o = INIT_DATA;
            end
            ST_UPDATE: begin
                fc_dllp_valid_o  = 1'b1;
                fc_dllp_type_o   = 1'b1;
                fc_hdr_credit_o  = lat_hdr_q;
                fc_data_credit_o = lat_data_q;
            end
            default: ;
        endcase
        avail_hdr_o    = (state_q == ST_IDLE) ? 8'd0  : avail_hdr;
        avail_data_o   = (state_q == ST_IDLE) ? 12'd0 : avail_data;
        overflow_err_o = ovf_q;
    end

    // Credit bookkeeping
    always_comb begin
        ca_hdr_d   = ca_hdr_q;
        ca_data_d  = ca_data_q;
        cr_hdr_d   = cr_hdr_q;
        cr_data_d  = cr_data_q;
        adv_hdr_d  = adv_hdr_q;
        adv_data_d = adv_data_q;
        lat_hdr_d  = lat_hdr_q;
        lat_data_d = lat_data_q;
        ovf_d      = ovf_q;
        if (!link_up_i) begin
            ca_hdr_d   = INIT_HDR;
            ca_data_d  = INIT_DATA;
            cr_hdr_d   = 8'd0;
            cr_data_d  = 12'd0;
            adv_hdr_d  = 8'd0;
            adv_data_d = 12'd0;
            lat_hdr_d  = 8'd0;
            lat_data_d = 12'd0;
            ovf_d      = 1'b0;
        end else begin
            if (counting) begin
                cr_hdr_d  = cr_hdr_q + cost_hdr;
                cr_data_d = cr_data_q + cost_data;
                if (rx_release_valid_i) begin
                    ca_hdr_d  = ca_hdr_q + rx_release_hdr_i;
                    ca_data_d = ca_data_q + rx_release_data_i;
                end
                // The offending TLP is still counted; only the flag records it.
                if ((cost_hdr > avail_hdr) || (cost_data > avail_data)) begin
                    ovf_d = 1'b1;
                end
            end
            if ((state_q == ST_INIT) && fc_dllp_ready_i) begin
                adv_hdr_d  = ca_hdr_q;
                adv_data_d = ca_data_q;
            end
            if ((state_q == ST_ACTIVE) && (state_d == ST_UPDATE)) begin
                lat_hdr_d  = ca_hdr_q;
                lat_data_d = ca_data_q;
            end
            if ((state_q == ST_UPDATE) && fc_dllp_ready_i) begin
                adv_hdr_d  = lat_hdr_q;
                adv_data_d = lat_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_hdr_q   <= INIT_HDR;
            ca_data_q  <= INIT_DATA;
            cr_hdr_q   <= 8'd0;
            cr_data_q  <= 12'd0;
            adv_hdr_q  <= 8'd0;
            adv_data_q <= 12'd0;
            lat_hdr_q  <= 8'd0;
            lat_data_q <= 12'd0;
            ovf_q      <= 1'b0;
        end else begin
            ca_hdr_q   <= ca_hdr_d;
            ca_data_q  <= ca_data_d;
            cr_hdr_q   <= cr_hdr_d;
            cr_data_q  <= cr_data_d;
            adv_hdr_q  <= adv_hdr_d;
            adv_data_q <= adv_data_d;
            lat_hdr_q  <= lat_hdr_d;
            lat_data_q <= lat_data_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fc_rx_credit_ctrl.sv
// tb/tb_fc_rx_credit_ctrl.sv - directed self-checking bench for fc_rx_credit_ctrl
module tb_fc_rx_credit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_up_i;
    logic        rx_tlp_valid_i;
    logic [1:0]  rx_tlp_type_i;
    logic [7:0]  rx_tlp_size_i;
    logic        rx_release_valid_i;
    logic [7:0]  rx_release_hdr_i;
    logic [11:0] rx_release_data_i;
    logic        fc_dllp_valid_o;
    logic        fc_dllp_ready_i;
    logic        fc_dllp_type_o;
    logic [7:0]  fc_hdr_credit_o;
    logic [11:0] fc_data_credit_o;
    logic [7:0]  avail_hdr_o;
    logic [11:0] avail_data_o;
    logic        overflow_err_o;

    int checks = 0;
    int errors = 0;

    fc_rx_credit_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .link_up_i          (link_up_i),
        .rx_tlp_valid_i     (rx_tlp_valid_i),
        .rx_tlp_type_i      (rx_tlp_type_i),
        .rx_tlp_size_i      (rx_tlp_size_i),
        .rx_release_valid_i (rx_release_valid_i),
        .rx_release_hdr_i   (rx_release_hdr_i),
        .rx_release_data_i  (rx_release_data_i),
        .fc_dllp_valid_o    (fc_dllp_valid_o),
        .fc_dllp_ready_i    (fc_dllp_ready_i),
        .fc_dllp_type_o     (fc_dllp_type_o),
        .fc_hdr_credit_o    (fc_hdr_credit_o),
        .fc_data_credit_o   (fc_data_credit_o),
        .avail_hdr_o        (avail_hdr_o),
        .avail_data_o       (avail_data_o),
        .overflow_err_o     (overflow_err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_fc(input string tag, input logic v, input logic t,
                          input logic [7:0] h, input logic [11:0] d);
        chk({tag, "_valid"}, {31'd0, fc_dllp_valid_o}, {31'd0, v});
        chk({tag, "_type"},  {31'd0, fc_dllp_type_o},  {31'd0, t});
        chk({tag, "_hdr"},   {24'd0, fc_hdr_credit_o}, {24'd0, h});
        chk({tag, "_data"},  {20'd0, fc_data_credit_o}, {20'd0, d});
    endtask

    task automatic chk_avail(input string tag, input logic [7:0] h, input logic [11:0] d);
        chk({tag, "_avail_hdr"},  {24'd0, avail_hdr_o},  {24'd0, h});
        chk({tag, "_avail_data"}, {20'd0, avail_data_o}, {20'd0, d});
    endtask

    task automatic tlp(input logic [1:0] t, input logic [7:0] sz);
        rx_tlp_valid_i = 1'b1;
        rx_tlp_type_i  = t;
        rx_tlp_size_i  = sz;
        step();
        rx_tlp_valid_i = 1'b0;
    endtask

    task automatic release_cr(input logic [7:0] h, input logic [11:0] d);
        rx_release_valid_i = 1'b1;
        rx_release_hdr_i   = h;
        rx_release_data_i  = d;
        step();
        rx_release_valid_i = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        link_up_i          = 1'b0;
        rx_tlp_valid_i     = 1'b0;
        rx_tlp_type_i      = 2'b00;
        rx_tlp_size_i      = 8'd0;
        rx_release_valid_i = 1'b0;
        rx_release_hdr_i   = 8'd0;
        rx_release_data_i  = 12'd0;
        fc_dllp_ready_i    = 1'b0;
        step();
        step();
        chk_fc("reset", 1'b0, 1'b0, 8'd0, 12'd0);
        chk_avail("reset", 8'd0, 12'd0);
        chk("reset_ovf", {31'd0, overflow_err_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // InitFC, stalled for three cycles
        link_up_i = 1'b1;
        step();
        chk_fc("init_c1", 1'b1, 1'b0, 8'd32, 12'd256);
        step();
        step();
        chk_fc("init_c3", 1'b1, 1'b0, 8'd32, 12'd256);
        fc_dllp_ready_i = 1'b1;
        step();
        fc_dllp_ready_i = 1'b0;
        chk("active_valid", {31'd0, fc_dllp_valid_o}, 32'd0);
        chk_avail("active", 8'd32, 12'd256);

        // MWr 16 DW, Cpl 5 DW, MRd, reserved type
        tlp(2'b00, 8'd16);
        chk_avail("mwr16", 8'd31, 12'd252);
        tlp(2'b10, 8'd5);
        tlp(2'b01, 8'd0);
        chk_avail("mix", 8'd29, 12'd250);
        tlp(2'b11, 8'd20);
        step();
        chk_avail("reserved", 8'd29, 12'd250);
        chk("no_update", {31'd0, fc_dllp_valid_o}, 32'd0);

        // Threshold UpdateFC, release during stall, second UpdateFC
        release_cr(8'd4, 12'd16);
        chk("upd_not_yet", {31'd0, fc_dllp_valid_o}, 32'd0);
        step();
        chk_fc("upd1", 1'b1, 1'b1, 8'd36, 12'd272);
        release_cr(8'd1, 12'd0);
        step();
        chk_fc("upd1_held", 1'b1, 1'b1, 8'd36, 12'd272);
        fc_dllp_ready_i = 1'b1;
        step();
        fc_dllp_ready_i = 1'b0;
        chk("upd1_done", {31'd0, fc_dllp_valid_o}, 32'd0);
        release_cr(8'd3, 12'd0);
        step();
        chk_fc("upd2", 1'b1, 1'b1, 8'd40, 12'd272);
        fc_dllp_ready_i = 1'b1;
        step();
        chk_avail("upd2_done", 8'd37, 12'd266);

        // Relink to get fresh counters
        link_up_i = 1'b0;
        step();
        link_up_i = 1'b1;
        step();
        chk_fc("relink1", 1'b1, 1'b0, 8'd32, 12'd256);
        step();
        fc_dllp_ready_i = 1'b0;
        chk_avail("relink1_active", 8'd32, 12'd256);

        // 33 back-to-back MRd against 32 header credits
        for (int i = 0; i < 33; i++) begin
            tlp(2'b01, 8'd0);
            if (i == 31) chk("ovf_after32", {31'd0, overflow_err_o}, 32'd0);
        end
        chk("ovf_after33", {31'd0, overflow_err_o}, 32'd1);
        chk("ovf_avail_hdr", {24'd0, avail_hdr_o}, 32'd255);
        step();
        chk("ovf_sticky", {31'd0, overflow_err_o}, 32'd1);

        // Stall an UpdateFC, then drop the link
        release_cr(8'd4, 12'd0);
        step();
        chk_fc("upd3", 1'b1, 1'b1, 8'd36, 12'd256);
        link_up_i = 1'b0;
        step();
        chk_fc("linkdown", 1'b0, 1'b0, 8'd0, 12'd0);
        chk("linkdown_ovf", {31'd0, overflow_err_o}, 32'd0);
        link_up_i = 1'b1;
        step();
        chk_fc("relink2", 1'b1, 1'b0, 8'd32, 12'd256);
        fc_dllp_ready_i = 1'b1;
        step();
        chk_avail("relink2_active", 8'd32, 12'd256);

        // CA_data/CR_data wrap: 62 x (MWr 255 DW = 64 credits, release 1/64)
        for (int i = 0; i < 62; i++) begin
            rx_tlp_valid_i     = 1'b1;
            rx_tlp_type_i      = 2'b00;
            rx_tlp_size_i      = 8'd255;
            rx_release_valid_i = 1'b1;
            rx_release_hdr_i   = 8'd1;
            rx_release_data_i  = 12'd64;
            step();
        end
        rx_tlp_valid_i     = 1'b0;
        rx_release_valid_i = 1'b0;
        chk_avail("wrap", 8'd32, 12'd256);
        chk("wrap_ovf", {31'd0, overflow_err_o}, 32'd0);
        tlp(2'b00, 8'd40);
        chk_avail("wrap_after", 8'd31, 12'd246);
        chk("wrap_after_ovf", {31'd0, overflow_err_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
